debug_dump_seq: RTL
===================

Name: debug_dump_seq

Overview:
- Sequencer that reads out the MIPS core's architectural state through the top-level debug read ports.
- Drives the register-file index (ReadReg) and data-memory index (ReadMem), and samples the returned RegData/MemData.
- Streams every word out on a valid/ready interface toward a host-side debug link (UART/LED harness).
- Sits beside top: it is the reader for the debug read ports that top exposes.

Parameters:
- NUM_REGS, 32, registers dumped (indices 0..NUM_REGS-1), legal 1..32
- NUM_WORDS, 64, data-memory words dumped (indices 0..NUM_WORDS-1), legal 1..64

Ports:
- CLK  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- Start  input  1  begin dump; sampled only in IDLE
- Abort  input  1  synchronous cancel of a dump in progress
- Busy  output  1  high from the cycle after accepted Start until return to IDLE
- Done  output  1  one-cycle pulse when the final beat has been accepted
- ReadReg  output  5  register index toward top, registered
- ReadMem  output  6  memory word index toward top, registered
- RegData  input  32  register contents, combinational from ReadReg
- MemData  input  32  memory contents, combinational from ReadMem
- OutValid  output  1  OutData/OutTag valid
- OutReady  input  1  sink accepts the beat when OutValid&&OutReady
- OutData  output  32  dumped word
- OutTag  output  8  source of the word: reg = {3'b000,idx[4:0]}; mem = {2'b10,idx[5:0]}; checksum = 8'hFF

Behaviour:
- Reset (Reset=0, async) forces: state IDLE; Busy=0; Done=0; OutValid=0; OutData=0; OutTag=0; ReadReg=0; ReadMem=0; internal counters=0.
- States: IDLE, REG_ADDR, REG_OUT, MEM_ADDR, MEM_OUT, [CSUM_OUT], FIN.
- IDLE: on Start=1, load ReadReg=0 and go to REG_ADDR. Busy rises the next cycle.
- REG_ADDR (1 cycle, lets ReadReg settle):
  - Capture OutData<=RegData and OutTag<={3'b000,ReadReg}.
  - Set OutValid<=1 and go to REG_OUT.
- REG_OUT: hold OutData/OutTag/OutValid stable until OutReady=1. On the handshake:
  - If ReadReg==NUM_REGS-1: ReadMem<=0, go to MEM_ADDR.
  - Otherwise: ReadReg<=ReadReg+1, go to REG_ADDR.
  - OutValid drops the same edge.
- MEM_ADDR/MEM_OUT: identical to the register pair, using MemData, ReadMem and tag {2'b10,ReadMem}. The last word goes to CSUM_OUT if the feature is enabled, otherwise to FIN.
- FIN: Done=1 for exactly one cycle, Busy<=0, go to IDLE. ReadReg/ReadMem hold their last values.
- Throughput: at most one beat per 2 cycles. With OutReady tied high, a full default dump takes 2*(32+64)+2 = 194 cycles from Start to the Done pulse.
- Stalls: OutValid, once raised, never drops without a handshake, except on Abort or Reset.
- Start while Busy is ignored.
- Abort=1 in any non-IDLE state: next edge goes to IDLE, OutValid=0, Busy=0, no Done. Abort has priority over a simultaneous handshake.
- Abort in IDLE is ignored. Start and Abort both high in IDLE: Start wins.
- Reset asserted mid-dump: immediate return to reset values. No partial beat is held afterwards.
- Index counters never wrap: the end comparison is against NUM_*-1.

Optional Feature:
- Macro: DUMP_CSUM_EN
- Defined:
  - A 32-bit running XOR accumulates the OutData of every accepted beat. It is cleared on the Start acceptance.
  - After the last memory beat, state CSUM_OUT presents OutData = accumulator, OutTag=8'hFF, OutValid=1 with the same handshake rules, then goes to FIN.
  - Default dump = 97 beats, 196 cycles with OutReady high.
- Undefined: no accumulator logic, no CSUM_OUT state, 96 beats.

Test Plan:
- Reg r_k=k*0x11111111 pattern, mem[w]=0xA5000000|w, OutReady=1, pulse Start -> 96 beats; beat 0 tag 0x00 data 0x00000000; beat 31 tag 0x1F; beat 32 tag 0x80 data 0xA5000000; beat 95 tag 0xBF data 0xA500003F; Done pulse on cycle 194; Busy low afterwards.
- OutReady toggled pseudo-randomly (e.g. high 1 in 3 cycles) -> same 96 beats in the same order; OutData/OutTag never change while OutValid&&!OutReady.
- Abort asserted while beat 40 is held (OutReady=0) -> OutValid=0 and Busy=0 next cycle, no Done. A new Start then restarts at tag 0x00.
- Reset driven low asynchronously mid-dump (between clock edges) -> OutValid, Busy and Done go low immediately without a clock edge. After release, Start yields a full dump from beat 0.
- Start pulsed again at beats 5 and 60 -> ignored: exactly 96 beats and one Done.
- DUMP_CSUM_EN defined, all regs 0, mem[w]=w -> 97th beat tag 0xFF data = XOR of 0..63 = 0x00000000. With mem[3]=0xDEADBEEF instead, data = 0xDEADBEEF^0x3 = 0xDEADBEEC.

Source files
------------

// File: rtl/debug_dump_seq.sv
// debug_dump_seq: streams every register and data-memory word out of the core over valid/ready; DUMP_CSUM_EN appends an XOR checksum beat
module debug_dump_seq #(
    parameter int NUM_REGS  = 32,
    parameter int NUM_WORDS = 64
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Abort,
    output logic        Busy,
    output logic        Done,
    output logic [4:0]  ReadReg,
    output logic [5:0]  ReadMem,
    input  logic [31:0] RegData,
    input  logic [31:0] MemData,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutData,
    output logic [7:0]  OutTag
);
`ifdef DUMP_CSUM_EN
    typedef enum logic [2:0] {IDLE, REG_ADDR, REG_OUT, MEM_ADDR, MEM_OUT, FIN, CSUM_OUT} state_t;
`else
    typedef enum logic [2:0] {IDLE, REG_ADDR, REG_OUT, MEM_ADDR, MEM_OUT, FIN} state_t;
`endif
    localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);
    localparam logic [5:0] LAST_MEM = 6'(NUM_WORDS - 1);
    state_t      state_q;
    logic        busy_q, done_q, valid_q;
    logic [4:0]  read_reg_q;
    logic [5:0]  read_mem_q;
    logic [31:0] data_q;
    logic [7:0]  tag_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign ReadReg  = read_reg_q;
    assign ReadMem  = read_mem_q;
    assign OutValid = valid_q;
    assign OutData  = data_q;
    assign OutTag   = tag_q;
`ifdef DUMP_CSUM_EN
    logic [31:0] acc_q;
    // running XOR of every accepted beat, restarted when a dump is accepted
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)
            acc_q <= '0;
        else if (state_q == IDLE && Start)
            acc_q <= '0;
        else if (valid_q && OutReady && !Abort)
            acc_q <= acc_q ^ data_q;
    end
`endif
    // dump sequencer: one address-settle cycle then a held beat per word
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            read_reg_q <= '0;
            read_mem_q <= '0;
            data_q     <= '0;
            tag_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && Abort) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (Start) begin
                        read_reg_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= REG_ADDR;
                    end
                    REG_ADDR: begin
                        data_q  <= RegData;
                        tag_q   <= {3'b000, read_reg_q};
                        valid_q <= 1'b1;
                        state_q <= REG_OUT;
                    end
                    REG_OUT: if (OutReady) begin
                        valid_q <= 1'b0;
                        if (read_reg_q == LAST_REG) begin
                            read_mem_q <= '0;
                            state_q    <= MEM_ADDR;
                        end else begin
                            read_reg_q <= read_reg_q + 5'd1;
                            state_q    <= REG_ADDR;
                        end
                    end
                    MEM_ADDR: begin
                        data_q  <= MemData;
                        tag_q   <= {2'b10, read_mem_q};
                        valid_q <= 1'b1;
                        state_q <= MEM_OUT;
                    end
                    MEM_OUT: if (OutReady) begin
                        valid_q <= 1'b0;
                        if (read_mem_q == LAST_MEM) begin
`ifdef DUMP_CSUM_EN
                            state_q <= CSUM_OUT;
`else
                            state_q <= FIN;
`endif
                        end else begin
                            read_mem_q <= read_mem_q + 6'd1;
                            state_q    <= MEM_ADDR;
                        end
                    end
`ifdef DUMP_CSUM_EN
                    CSUM_OUT: if (!valid_q) begin
                        data_q  <= acc_q;
                        tag_q   <= 8'hFF;
                        valid_q <= 1'b1;
                    end else if (OutReady) begin
                        valid_q <= 1'b0;
                        state_q <= FIN;
                    end
`endif
                    FIN: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule
